// File: rtl/vector_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vector_lsu_pkg : encodings shared by the core pipeline, scheduler,
// |                  register file and load/store unit.
// | Revision       : 1.0
// +----------------------------------------------------------------------------
package vector_lsu_pkg;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // A single-lane configuration still needs a one-bit lane counter.
  function automatic int lane_idx_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_lsu_mem_req_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mem_req_channel : registered valid/address/data request, released on the
// |                   edge where ready is sampled high.
// | Revision        : 1.0
// +----------------------------------------------------------------------------
module mem_req_channel
  import vector_lsu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 ready,
  output logic                 valid,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] data,
  output logic                 fire
);

  logic                 valid_q, valid_d;
  logic [ADDR_BITS-1:0] address_q, address_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  assign fire = enable & valid_q & ready;

  always_comb begin
    valid_d   = valid_q;
    address_d = address_q;
    data_d    = data_q;
    if (enable && load) begin
      valid_d   = 1'b1;
      address_d = load_address;
      data_d    = load_data;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      address_q <= address_d;
      data_q    <= data_d;
    end
  end

  assign valid   = valid_q;
  assign address = address_q;
  assign data    = data_q;

endmodule
`default_nettype wire

// File: rtl/vector_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vector_lsu : scalar/vector load-store unit; vector accesses walk one lane
// |              per memory transaction starting at v_rs lane 0.
// | Revision   : 1.0
// +----------------------------------------------------------------------------
module vector_lsu
  import vector_lsu_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 8,
  parameter int Vector_Size = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic                             decoded_mem_read_enable,
  input  logic                             decoded_mem_write_enable,
  input  logic                             decoded_vector_mux,
  input  logic [DATA_BITS-1:0]             rs,
  input  logic [DATA_BITS-1:0]             rt,
  input  logic [DATA_BITS*Vector_Size-1:0] v_rs,
  input  logic [DATA_BITS*Vector_Size-1:0] v_rt,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output logic [1:0]                       lsu_state,
  output logic [DATA_BITS-1:0]             lsu_out,
  output logic [DATA_BITS*Vector_Size-1:0] v_lsu_out
);

  localparam int LANE_BITS = lane_idx_bits(Vector_Size);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(Vector_Size - 1);

  lsu_state_e           state_q, state_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic                 op_read_q, op_read_d;
  logic                 op_vec_q, op_vec_d;
  logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;
  logic [DATA_BITS-1:0] v_lsu_q [Vector_Size];
  logic [DATA_BITS-1:0] v_lsu_d [Vector_Size];

  logic [DATA_BITS-1:0]             v_rt_lane [Vector_Size];
  logic [DATA_BITS*Vector_Size-1:0] v_rs_unused;
  logic [DATA_BITS-1:0]             rd_data_unused;
  logic [ADDR_BITS-1:0]             base_addr;
  logic [ADDR_BITS-1:0]             req_addr;
  logic [DATA_BITS-1:0]             req_wdata;
  logic                             rd_load, wr_load;
  logic                             rd_fire, wr_fire, req_fire;

  // Only lane 0 of v_rs carries the base address.
  assign v_rs_unused = v_rs;

  for (genvar i = 0; i < Vector_Size; i++) begin : g_lane
    assign v_rt_lane[i]                         = v_rt[i*DATA_BITS +: DATA_BITS];
    assign v_lsu_out[i*DATA_BITS +: DATA_BITS] = v_lsu_q[i];
  end

  assign base_addr = op_vec_q ? ADDR_BITS'(v_rs[DATA_BITS-1:0]) : ADDR_BITS'(rs);
  assign req_addr  = base_addr + ADDR_BITS'(lane_q);
  assign req_wdata = op_vec_q ? v_rt_lane[lane_q] : rt;
  assign rd_load   = (state_q == LSU_REQUESTING) && op_read_q;
  assign wr_load   = (state_q == LSU_REQUESTING) && !op_read_q;
  assign req_fire  = op_read_q ? rd_fire : wr_fire;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    op_read_d = op_read_q;
    op_vec_d  = op_vec_q;
    lsu_out_d = lsu_out_q;
    v_lsu_d   = v_lsu_q;
    if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            state_d   = LSU_REQUESTING;
            lane_d    = '0;
            op_read_d = decoded_mem_read_enable;
            op_vec_d  = decoded_vector_mux;
          end
        end
        LSU_REQUESTING: state_d = LSU_WAITING;
        LSU_WAITING: begin
          if (req_fire) begin
            if (op_read_q) begin
              if (op_vec_q) v_lsu_d[lane_q] = mem_read_data;
              else          lsu_out_d       = mem_read_data;
            end
            if (op_vec_q && lane_q != LAST_LANE) begin
              lane_d  = lane_q + LANE_BITS'(1);
              state_d = LSU_REQUESTING;
            end else begin
              state_d = LSU_DONE;
            end
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LSU_IDLE;
      lane_q    <= '0;
      op_read_q <= 1'b0;
      op_vec_q  <= 1'b0;
      lsu_out_q <= '0;
      v_lsu_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      op_read_q <= op_read_d;
      op_vec_q  <= op_vec_d;
      lsu_out_q <= lsu_out_d;
      v_lsu_q   <= v_lsu_d;
    end
  end

  mem_req_channel #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_rd_chan (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (rd_load),
    .load_address(req_addr),
    .load_data   ({DATA_BITS{1'b0}}),
    .ready       (mem_read_ready),
    .valid       (mem_read_valid),
    .address     (mem_read_address),
    .data        (rd_data_unused),
    .fire        (rd_fire)
  );

  mem_req_channel #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_wr_chan (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (wr_load),
    .load_address(req_addr),
    .load_data   (req_wdata),
    .ready       (mem_write_ready),
    .valid       (mem_write_valid),
    .address     (mem_write_address),
    .data        (mem_write_data),
    .fire        (wr_fire)
  );

  assign lsu_state = state_q;
  assign lsu_out   = lsu_out_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_vector_lsu : directed bench for vector_lsu with a behavioural memory.
// | Revision      : 1.0
// +----------------------------------------------------------------------------
module tb_vector_lsu;

  localparam logic [2:0] CS_IDLE    = 3'b000;
  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_WAIT    = 3'b100;
  localparam logic [2:0] CS_UPDATE  = 3'b110;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_REQ = 2'b01, ST_WAIT = 2'b10, ST_DONE = 2'b11;

  logic        clk, reset, enable;
  logic [2:0]  core_state;
  logic        rd_en, wr_en, vec;
  logic [7:0]  rs, rt;
  logic [31:0] v_rs, v_rt;
  logic        mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [7:0]  mem_read_address, mem_read_data, mem_write_address, mem_write_data;
  logic [1:0]  lsu_state;
  logic [7:0]  lsu_out;
  logic [31:0] v_lsu_out;

  vector_lsu dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .decoded_vector_mux(vec), .rs(rs), .rt(rt), .v_rs(v_rs), .v_rt(v_rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .v_lsu_out(v_lsu_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [256];
  logic [7:0] rd_addr_log[$], wr_addr_log[$], wr_data_log[$];
  int  lat, stall_idx, stall_lat, wait_cnt, txn_idx, both_seen, hold_bad;
  bit  tie_high, force_rdy, rdy, prev_wv, prev_wfire;
  logic [7:0] prev_wa, prev_wd;
  int  n_pass, n_total;

  // Memory responder and transaction log; runs mid-low-phase so the values it
  // acts on are exactly those the next rising edge will sample.
  always begin
    @(negedge clk);
    #2;
    if (reset || !(mem_read_valid || mem_write_valid)) wait_cnt = 0;
    rdy = tie_high || force_rdy ||
          ((mem_read_valid || mem_write_valid) &&
           wait_cnt >= ((txn_idx == stall_idx) ? stall_lat : lat));
    mem_read_ready  = rdy;
    mem_write_ready = rdy;
    mem_read_data   = mem[mem_read_address];
    if (mem_write_valid && prev_wv && !prev_wfire && !reset &&
        (mem_write_address !== prev_wa || mem_write_data !== prev_wd)) hold_bad++;
    prev_wfire = 1'b0;
    if (!reset && enable) begin
      if (mem_read_valid && rdy) begin
        rd_addr_log.push_back(mem_read_address);
        txn_idx++;
      end else if (mem_write_valid && rdy) begin
        wr_addr_log.push_back(mem_write_address);
        wr_data_log.push_back(mem_write_data);
        mem[mem_write_address] = mem_write_data;
        txn_idx++;
        prev_wfire = 1'b1;
      end else if (mem_read_valid || mem_write_valid) begin
        wait_cnt++;
      end
    end
    if (mem_read_valid && mem_write_valid) both_seen++;
    prev_wv = mem_write_valid && !reset;
    prev_wa = mem_write_address;
    prev_wd = mem_write_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    txn_idx = 0;
  endtask

  // Present a request for one cycle; returns at the negedge after the REQUEST edge.
  task automatic issue(input logic r, input logic w, input logic v);
    rd_en = r; wr_en = w; vec = v;
    core_state = CS_REQUEST;
    @(negedge clk);
    core_state = CS_WAIT;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lsu_state !== st && n < max_cyc);
    check(tag, lsu_state, st);
  endtask

  task automatic finish_update(input string tag);
    core_state = CS_UPDATE;
    @(negedge clk);
    check(tag, lsu_state, ST_IDLE);
    core_state = CS_IDLE;
  endtask

  initial begin
    int n;
    n_pass = 0; n_total = 0;
    reset = 1'b1; enable = 1'b1; core_state = CS_IDLE;
    rd_en = 0; wr_en = 0; vec = 0; rs = 0; rt = 0; v_rs = 0; v_rt = 0;
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;
    lat = 0; stall_idx = -1; stall_lat = 0; wait_cnt = 0; txn_idx = 0;
    both_seen = 0; hold_bad = 0; tie_high = 0; force_rdy = 0;
    prev_wv = 0; prev_wfire = 0; prev_wa = 0; prev_wd = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5C);

    repeat (2) @(negedge clk);
    check("rst_state", lsu_state, ST_IDLE);
    check("rst_rvalid", mem_read_valid, 1'b0);
    check("rst_wvalid", mem_write_valid, 1'b0);
    check("rst_raddr", mem_read_address, 8'h00);
    check("rst_waddr", mem_write_address, 8'h00);
    check("rst_wdata", mem_write_data, 8'h00);
    check("rst_lsu_out", lsu_out, 8'h00);
    check("rst_v_lsu_out", v_lsu_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Scalar LDR, ready two cycles after valid
    mem[8'h10] = 8'hA5; rs = 8'h10; lat = 1;
    clear_logs();
    issue(1, 0, 0);
    check("ldr_requesting", lsu_state, ST_REQ);
    @(negedge clk);
    check("ldr_rvalid", mem_read_valid, 1'b1);
    check("ldr_raddr", mem_read_address, 8'h10);
    check("ldr_no_wvalid", mem_write_valid, 1'b0);
    wait_state("ldr_done", ST_DONE, 10, n);
    check("ldr_lsu_out", lsu_out, 8'hA5);
    check("ldr_rd_count", rd_addr_log.size(), 1);
    check("ldr_rd_addr", rd_addr_log[0], 8'h10);
    repeat (2) @(negedge clk);
    check("ldr_done_hold", lsu_state, ST_DONE);
    check("ldr_out_hold", lsu_out, 8'hA5);
    finish_update("ldr_idle");

    // Scalar STR, ready tied high
    tie_high = 1; rs = 8'h20; rt = 8'h3C;
    clear_logs();
    issue(0, 1, 0);
    wait_state("str_done", ST_DONE, 10, n);
    check("str_latency", n + 1, 3);
    check("str_wr_count", wr_addr_log.size(), 1);
    check("str_wr_addr", wr_addr_log[0], 8'h20);
    check("str_wr_data", wr_data_log[0], 8'h3C);
    check("str_rd_count", rd_addr_log.size(), 0);
    check("str_mem", mem[8'h20], 8'h3C);
    finish_update("str_idle");
    tie_high = 0;

    // Vector LDR wrapping past the top of memory
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    v_rs = 32'h998877FE; lat = 0;
    clear_logs();
    issue(1, 0, 1);
    wait_state("vldr_done", ST_DONE, 30, n);
    check("vldr_latency", n + 1, 9);
    check("vldr_v_lsu_out", v_lsu_out, 32'h44332211);
    check("vldr_rd_count", rd_addr_log.size(), 4);
    check("vldr_rd_addrs", {rd_addr_log[3], rd_addr_log[2], rd_addr_log[1], rd_addr_log[0]}, 32'h0100FFFE);
    check("vldr_lsu_out_kept", lsu_out, 8'hA5);
    finish_update("vldr_idle");

    // Vector STR with a five-cycle stall on lane 2
    v_rs = 32'h00000040; v_rt = 32'hD4C3B2A1; stall_idx = 2; stall_lat = 5; hold_bad = 0;
    clear_logs();
    issue(0, 1, 1);
    wait_state("vstr_done", ST_DONE, 40, n);
    check("vstr_latency", n + 1, 14);
    check("vstr_wr_count", wr_addr_log.size(), 4);
    check("vstr_wr_addrs", {wr_addr_log[3], wr_addr_log[2], wr_addr_log[1], wr_addr_log[0]}, 32'h43424140);
    check("vstr_wr_data", {wr_data_log[3], wr_data_log[2], wr_data_log[1], wr_data_log[0]}, 32'hD4C3B2A1);
    check("vstr_stall_stable", hold_bad, 0);
    check("vstr_rd_count", rd_addr_log.size(), 0);
    finish_update("vstr_idle");
    stall_idx = -1;

    // Reset while waiting on lane 1 of a vector load
    mem[8'h80] = 8'h5A; v_rs = 32'h00000080; lat = 3;
    clear_logs();
    issue(1, 0, 1);
    n = 0;
    while (!(txn_idx == 1 && lsu_state == ST_WAIT) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached", lsu_state, ST_WAIT);
    check("rstmid_lane0", v_lsu_out, 32'h4433225A);
    check("rstmid_rvalid_pre", mem_read_valid, 1'b1);
    check("rstmid_raddr_pre", mem_read_address, 8'h81);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_state", lsu_state, ST_IDLE);
    check("rstmid_rvalid", mem_read_valid, 1'b0);
    check("rstmid_wvalid", mem_write_valid, 1'b0);
    check("rstmid_raddr", mem_read_address, 8'h00);
    check("rstmid_v_lsu_out", v_lsu_out, 32'h0);
    check("rstmid_lsu_out", lsu_out, 8'h00);
    reset = 1'b0;
    core_state = CS_IDLE;
    @(negedge clk);

    // Read and write both decoded: read wins
    mem[8'h05] = 8'h6B; rs = 8'h05; rt = 8'hEE; lat = 0;
    clear_logs();
    issue(1, 1, 0);
    wait_state("both_done", ST_DONE, 10, n);
    check("both_rd_count", rd_addr_log.size(), 1);
    check("both_rd_addr", rd_addr_log[0], 8'h05);
    check("both_wr_count", wr_addr_log.size(), 0);
    check("both_lsu_out", lsu_out, 8'h6B);
    finish_update("both_idle");

    // Enable dropped for three cycles while WAITING, ready forced high
    mem[8'h30] = 8'h77; rs = 8'h30; lat = 10;
    clear_logs();
    issue(1, 0, 0);
    @(negedge clk);
    check("en_waiting", lsu_state, ST_WAIT);
    enable = 1'b0; force_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_hold_state", lsu_state, ST_WAIT);
      check("en_hold_rvalid", mem_read_valid, 1'b1);
      check("en_hold_raddr", mem_read_address, 8'h30);
    end
    check("en_no_fire", rd_addr_log.size(), 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_done", lsu_state, ST_DONE);
    check("en_lsu_out", lsu_out, 8'h77);
    check("en_rd_count", rd_addr_log.size(), 1);
    force_rdy = 0;
    finish_update("en_idle");

    check("never_both_valid", both_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
